// File: rtl/fan_speed_ramp_ctrl.sv
// Multi-level fan speed controller: button-stepped level, slew-limited duty ramp
// toward the level's target duty, and a free-running PWM generator driving the fan pin.
module fan_speed_ramp_ctrl #(
    parameter int unsigned SYS_FREQ  = 125,
    parameter int unsigned N         = 12,
    parameter int unsigned LEVELS    = 7,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned RAMP_STEP = 64,
    parameter int unsigned RAMP_DIV  = 125000,
    parameter int unsigned PWM_DIV   = 150
) (
    input  logic                         clk,
    input  logic                         reset_p,
    input  logic                         btn,
    input  logic                         btn_back,
    input  logic                         fan_en,
    input  logic                         set_idle,
    output logic [$clog2(LEVELS+1)-1:0]  level,
    output logic [N-1:0]                 duty,
    output logic                         pwm,
    output logic                         running,
    output logic                         at_target
);

    localparam int unsigned LW   = $clog2(LEVELS + 1);
    localparam int unsigned NX   = N + 1;
    localparam int unsigned RW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned PW   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned DMAX = (2 ** N) - 1;
    localparam int unsigned STEP = DMAX / LEVELS;

    // Elaboration-time parameter sanity check
    if (SYS_FREQ == 0 || LEVELS < 1 || RAMP_DIV < 1 || PWM_DIV < 1 ||
        RAMP_STEP < 1 || RAMP_STEP > DMAX) begin : g_bad_params
        $error("fan_speed_ramp_ctrl: illegal parameter combination");
    end

    logic [LW-1:0] level_q, level_d;
    logic [N-1:0]  duty_q, duty_d;
    logic [N-1:0]  target_c;
    logic [RW-1:0] rcnt_q;
    logic [PW-1:0] pcnt_q;
    logic [N-1:0]  cnt_q;
    logic          pwm_q;
    logic          tick_c;
    logic          ptick_c;
    logic [N:0]    duty_x, tgt_x, step_x, up_x;

    assign tick_c  = (rcnt_q == RW'(RAMP_DIV - 1));
    assign ptick_c = (pcnt_q == PW'(PWM_DIV - 1));

    // Level stepping; simultaneous buttons cancel
    always_comb begin
        level_d = level_q;
        if (!fan_en || set_idle) begin
            level_d = '0;
        end else if (btn && !btn_back) begin
            if (level_q == LW'(LEVELS)) level_d = (WRAP != 0) ? '0 : level_q;
            else                        level_d = level_q + LW'(1);
        end else if (btn_back && !btn) begin
            if (level_q == '0) level_d = (WRAP != 0) ? LW'(LEVELS) : level_q;
            else               level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        if (level_q == LW'(LEVELS)) target_c = N'(DMAX);
        else                        target_c = N'(32'(level_q) * STEP);
    end

    // Slew duty toward target in N+1 bits so neither direction can wrap or overshoot
    always_comb begin
        duty_x = {1'b0, duty_q};
        tgt_x  = {1'b0, target_c};
        step_x = NX'(RAMP_STEP);
        up_x   = duty_x + step_x;
        duty_d = duty_q;
        if (!fan_en) begin
            duty_d = '0;
        end else if (tick_c) begin
            if (duty_x < tgt_x)
                duty_d = (up_x > tgt_x) ? target_c : up_x[N-1:0];
            else if (duty_x > tgt_x)
                duty_d = (duty_x < tgt_x + step_x) ? target_c : N'(duty_x - step_x);
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            level_q <= '0;
            duty_q  <= '0;
            rcnt_q  <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            rcnt_q  <= tick_c ? '0 : rcnt_q + RW'(1);
            if (ptick_c) begin
                pcnt_q <= '0;
                cnt_q  <= (cnt_q == N'(DMAX - 1)) ? '0 : cnt_q + N'(1);
            end else begin
                pcnt_q <= pcnt_q + PW'(1);
            end
            // Counter tops out at DMAX-1 so full duty yields a constant high
            pwm_q <= (cnt_q < duty_q);
        end
    end

    assign level     = level_q;
    assign duty      = duty_q;
    assign pwm       = pwm_q;
    assign running   = (duty_q != '0);
    assign at_target = (duty_q == target_c);

endmodule
